// File: rtl/mbm_barrel_shift_pipe.sv
`timescale 1ns/1ps
// mbm_barrel_shift_pipe
// ---------------------------------------------------------------------------
// Parametrised barrel shifter for the MBM datapath. It sits between the
// leading-one detector and the Mitchell log-add stage and accepts one operand
// per cycle. A valid/ready handshake gives full backpressure, and a
// synchronous flush discards everything in flight.
//
// Shift modes (mode):
//   2'b00 rotate right, 2'b01 rotate left,
//   2'b10 logical shift right, 2'b11 logical shift left
//
// Build option BSHIFT_PIPE_EN:
//   defined   - one register after each of the L shift levels (latency L)
//   undefined - all L levels combinational, one output register (latency 1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of all valid bits; blocks input that cycle
//   in_valid   operand present on B/k/mode
//   in_ready   operand taken when in_valid && in_ready
//   B [N-1:0]  operand
//   k [L-1:0]  shift amount, 0..N-1
//   mode [1:0] shift mode (see above)
//   out_valid  result present on y/x
//   out_ready  result taken when out_valid && out_ready
//   y [N-1:0]  full shifted word
//   x [N-2:0]  mantissa fraction, y[N-1:1]
// ---------------------------------------------------------------------------
module mbm_barrel_shift_pipe #(
  parameter int N = 16,
  parameter int L = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] B,
  input  logic [L-1:0] k,
  input  logic [1:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y,
  output logic [N-2:0] x
);

`ifdef BSHIFT_PIPE_EN
  localparam int Stages = L;
`else
  localparam int Stages = 1;
`endif

  // One shift level: moves the word by a fixed amount when enabled.
  // Rotates wrap the bits shifted out back in; logical shifts fill zeros.
  function automatic logic [N-1:0] shiftLevel(
    input logic [N-1:0] d,
    input logic         en,
    input int unsigned  amt,
    input logic [1:0]   m
  );
    logic [N-1:0] r;
    r = d;
    if (en) begin
      case (m)
        2'b00:   r = (d >> amt) | (d << (N - amt));
        2'b01:   r = (d << amt) | (d >> (N - amt));
        2'b10:   r = d >> amt;
        default: r = d << amt;
      endcase
    end
    return r;
  endfunction

  logic [Stages-1:0] validQ;
  logic [N-1:0]      dataQ [Stages];
  logic [Stages-1:0] srcValid;
  logic [N-1:0]      dataD [Stages];
  logic [Stages-1:0] stageLoad;

  // Ready chain, walked from the output back to the input. A stage may load
  // when it is empty or when whatever it holds is leaving this cycle, so a
  // full pipeline with out_ready high still accepts without a bubble.
  always_comb begin : readyChain
    logic downstreamReady;
    stageLoad       = '0;
    downstreamReady = out_ready;
    for (int s = Stages - 1; s >= 0; s--) begin
      stageLoad[s]    = !validQ[s] || downstreamReady;
      downstreamReady = stageLoad[s];
    end
  end

`ifdef BSHIFT_PIPE_EN
  logic [L-1:0] kQ      [Stages];
  logic [1:0]   modeQ   [Stages];
  logic [N-1:0] srcData [Stages];
  logic [L-1:0] srcK    [Stages];
  logic [1:0]   srcMode [Stages];

  // Stage s consumes the register of stage s-1 (stage 0 the input ports)
  // and applies level s, which handles shift bit k[L-1-s] (weight 2^(L-1-s)).
  always_comb begin
    srcValid = '0;
    srcData  = '{default: '0};
    srcK     = '{default: '0};
    srcMode  = '{default: '0};
    dataD    = '{default: '0};
    srcValid[0] = in_valid;
    srcData[0]  = B;
    srcK[0]     = k;
    srcMode[0]  = mode;
    for (int s = 1; s < Stages; s++) begin
      srcValid[s] = validQ[s-1];
      srcData[s]  = dataQ[s-1];
      srcK[s]     = kQ[s-1];
      srcMode[s]  = modeQ[s-1];
    end
    for (int s = 0; s < Stages; s++) begin
      dataD[s] = shiftLevel(srcData[s], srcK[s][L-1-s], 1 << (L - 1 - s), srcMode[s]);
    end
  end

  // Shift amount and mode travel alongside the data so later levels see
  // the controls that belong to their own operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < Stages; s++) begin
        kQ[s]    <= '0;
        modeQ[s] <= '0;
      end
    end else begin
      for (int s = 0; s < Stages; s++) begin
        if (stageLoad[s]) begin
          kQ[s]    <= srcK[s];
          modeQ[s] <= srcMode[s];
        end
      end
    end
  end
`else
  // Applies all L levels back to back, largest shift first.
  function automatic logic [N-1:0] shiftAll(
    input logic [N-1:0] d,
    input logic [L-1:0] kk,
    input logic [1:0]   m
  );
    logic [N-1:0] r;
    r = d;
    for (int j = 0; j < L; j++) begin
      r = shiftLevel(r, kk[L-1-j], 1 << (L - 1 - j), m);
    end
    return r;
  endfunction

  always_comb begin
    srcValid    = '0;
    dataD       = '{default: '0};
    srcValid[0] = in_valid;
    dataD[0]    = shiftAll(B, k, mode);
  end
`endif

  // Valid and data registers. Flush clears every valid bit; data is left to
  // load normally since an invalid slot's contents are never observed.
  // A stage that cannot load holds both valid and data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validQ <= '0;
      for (int s = 0; s < Stages; s++) begin
        dataQ[s] <= '0;
      end
    end else begin
      for (int s = 0; s < Stages; s++) begin
        if (flush) begin
          validQ[s] <= 1'b0;
        end else if (stageLoad[s]) begin
          validQ[s] <= srcValid[s];
        end
        if (stageLoad[s]) begin
          dataQ[s] <= dataD[s];
        end
      end
    end
  end

  assign in_ready  = stageLoad[0] && !flush;
  assign out_valid = validQ[Stages-1];
  assign y         = dataQ[Stages-1];
  assign x         = y[N-1:1];

endmodule

// File: doc/mbm_barrel_shift_pipe.md
# mbm_barrel_shift_pipe

Parametrised, pipelined barrel shifter for the MBM datapath. It replaces the fixed 8-bit rotate used for mantissa alignment with an N-bit, L-level shifter that supports four shift modes. A valid/ready handshake with full backpressure and a synchronous flush lets it sit between the leading-one detector and the Mitchell log-add stage at one operand per cycle.

## Interface
- N, default 16: data width; power of two, minimum 4
- L, default 4: shift-amount width; must equal log2(N)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous pipeline clear
- in_valid  input  1  operand present
- in_ready  output  1  operand accepted when in_valid && in_ready
- B  input  N  operand
- k  input  L  shift amount, 0..N-1
- mode  input  2  00 rotate right, 01 rotate left, 10 logical shift right, 11 logical shift left
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts when out_valid && out_ready
- y  output  N  full shifted word
- x  output  N-1  mantissa fraction, y[N-1:1]

## Operation
- Level j (j = 0..L-1) shifts by 2^(L-1-j) when k[L-1-j] = 1; otherwise it passes data unchanged. k and mode travel with the data.
- Rotate modes wrap bits around. Logical modes fill with zeros.
- k = 0 → y = B in every mode.
- All arithmetic is unsigned. No value of k can exceed the range (k < N by width).
- Each pipeline register holds {valid, data, remaining k, mode}.
- Stage readiness:
  - last stage: ready = out_ready
  - stage i: ready_i = !valid_(i+1) || ready_(i+1)
  - stage i loads when !valid_i || ready_i
  - in_ready = (!valid_0 || ready_0) && !flush
  - the ready chain is combinational.
- A stalled stage holds data and valid stable.
- out_valid must not depend combinationally on out_ready.
- flush:
  - all valid bits clear on the next edge; in-flight data is discarded.
  - in_ready is low during flush, so an input offered in the flush cycle is not accepted.
  - out_valid drops the cycle after flush.
- Reset (any time, including mid-stream): all valid bits → 0 asynchronously; data registers → 0.

## Timing
- Reset values: out_valid = 0, y = 0, x = 0. in_ready = 1 once rst_n is high and flush is low.
- Latency, accept to out_valid, with no stall: L cycles with BSHIFT_PIPE_EN defined, 1 cycle without.
- Throughput: one operand per cycle while out_ready is held high.
- Full pipeline with out_ready = 0: in_ready goes low in the same cycle.
- out_ready rising with the pipeline full: in_ready rises in that same cycle, so there are no bubbles.
- Simultaneous accept and emit with the pipeline full: occupancy is unchanged.

## Configuration
- Macro: BSHIFT_PIPE_EN.
- Defined:
  - one register after each of the L shift levels
  - latency L
  - maximum logic depth is one mux level per stage.
- Undefined:
  - all L levels are combinational, followed by a single output register
  - latency 1
  - handshake, flush and reset rules are identical; the pipeline has one stage.

## Test plan
- Reset: assert rst_n = 0 mid-stream with 3 operands in flight → out_valid = 0 and y = 0 immediately. After release, in_ready = 1 and no stale results appear.
- Modes (N=16, defaults), each result appearing L cycles after accept:
  - B=16'h8001, k=4, mode 00 → y=16'h1800, x=15'h0C00
  - B=16'h8001, k=1, mode 01 → y=16'h0003
  - B=16'hF000, k=8, mode 10 → y=16'h00F0
  - B=16'h00FF, k=12, mode 11 → y=16'hF000
- Boundaries:
  - k=0 in all modes → y=B
  - k=15 with B=16'h0001, mode 01 → 16'h8000
  - k=15 with B=16'h0001, mode 10 → 16'h0000
- Backpressure: stream 20 random operands with out_ready toggling pseudo-randomly → outputs in order, none lost or duplicated; y and x stable while out_valid && !out_ready; in_ready low only when full.
- Flush: with 4 operands in flight, assert flush for one cycle together with in_valid → out_valid = 0 next cycle, the concurrent input is not accepted, and the next accepted operand emerges after normal latency.
- Configuration: rerun the mode and backpressure tests with BSHIFT_PIPE_EN undefined → identical result sequence, latency 1.
